// File: rtl/doorbell_melody_seq_if.sv
// Doorbell melody sequencer bus: button-side controls and buzzer/display status.
interface doorbell_melody_seq_if #(
  parameter int unsigned SW = 4
) ();

  logic          TRIG;
  logic          STOP;
  logic [1:0]    TRCK;
  logic          BEEP;
  logic          BUSY;
  logic          DONE;
  logic [SW-1:0] STEP;
  logic [3:0]    NOTE;

  // Button/controller side drives the controls and observes the status.
  modport master (
    output TRIG, STOP, TRCK,
    input  BEEP, BUSY, DONE, STEP, NOTE
  );

  // Sequencer side.
  modport slave (
    input  TRIG, STOP, TRCK,
    output BEEP, BUSY, DONE, STEP, NOTE
  );

endinterface

// File: rtl/doorbell_melody_seq.sv
// Doorbell melody sequencer: plays a ROM track as a square wave on BEEP,
// with restart, abort, repeat passes and a completion pulse.
module doorbell_melody_seq #(
  parameter int unsigned CLK_HZ     = 50_000_000,
  parameter int unsigned NOTE_TICKS = 16_777_216,
  parameter int unsigned N_TRACKS   = 4,
  parameter int unsigned TRACK_LEN  = 16,
  parameter int unsigned REPEATS    = 1
) (
  input logic                  CLK,
  input logic                  RST,
  doorbell_melody_seq_if.slave bus
);

  localparam int unsigned SW  = (TRACK_LEN > 1) ? $clog2(TRACK_LEN) : 1;
  localparam int unsigned NCW = (NOTE_TICKS > 1) ? $clog2(NOTE_TICKS) : 1;

  // Half-period in clocks for a tone, never below one cycle.
  function automatic int unsigned half_of(input int unsigned hz);
    int unsigned h;
    h = CLK_HZ / (2 * hz);
    return (h == 0) ? 1 : h;
  endfunction

  localparam int unsigned HALF_C4 = half_of(262);
  localparam int unsigned HALF_D4 = half_of(294);
  localparam int unsigned HALF_E4 = half_of(330);
  localparam int unsigned HALF_F4 = half_of(349);
  localparam int unsigned HALF_G4 = half_of(392);
  localparam int unsigned HALF_A4 = half_of(440);
  localparam int unsigned HALF_B4 = half_of(494);

  // C4 has the longest half-period, so it sizes the tone counter.
  localparam int unsigned TCW = (HALF_C4 > 1) ? $clog2(HALF_C4) : 1;

  // Track ROM, one nibble per step, step 0 in the least significant nibble.
  localparam logic [63:0] TRK0 = 64'hFFFF_FFFF_F765_4321;
  localparam logic [63:0] TRK1 = 64'hF122_3344_0566_5511;
  localparam logic [63:0] TRK2 = 64'hF543_0543_1321_1321;
  localparam logic [63:0] TRK3 = 64'hFFFF_FFFF_FFFF_F035;

  localparam logic [3:0] CODE_END = 4'hF;

  typedef enum logic [0:0] {
    S_IDLE,
    S_PLAY
  } state_t;

  // Note code at a step of a track; anything past the stored steps reads as end.
  function automatic logic [3:0] rom_note(input logic [1:0] t, input logic [5:0] i);
    logic [63:0] word;
    case (t)
      2'd0:    word = TRK0;
      2'd1:    word = TRK1;
      2'd2:    word = TRK2;
      default: word = TRK3;
    endcase
    if (i >= 6'd16) return CODE_END;
    return word[{i[3:0], 2'b00} +: 4];
  endfunction

  // Terminal value of the tone counter for a code; zero for rests.
  function automatic logic [TCW-1:0] half_m1(input logic [3:0] code);
    case (code)
      4'd1:    return TCW'(HALF_C4 - 1);
      4'd2:    return TCW'(HALF_D4 - 1);
      4'd3:    return TCW'(HALF_E4 - 1);
      4'd4:    return TCW'(HALF_F4 - 1);
      4'd5:    return TCW'(HALF_G4 - 1);
      4'd6:    return TCW'(HALF_A4 - 1);
      4'd7:    return TCW'(HALF_B4 - 1);
      default: return '0;
    endcase
  endfunction

  state_t         state_q, state_d;
  logic [1:0]     trk_q, trk_d;
  logic [SW-1:0]  step_q, step_d;
  logic [3:0]     note_q, note_d;
  logic [3:0]     pass_q, pass_d;
  logic [NCW-1:0] note_cnt_q, note_cnt_d;
  logic [TCW-1:0] tone_cnt_q, tone_cnt_d;
  logic           beep_q, beep_d;
  logic           busy_q, busy_d;
  logic           done_q, done_d;

  logic [1:0]     start_trk;
  logic [5:0]     nxt_idx;
  logic [3:0]     nxt_code;
  logic           note_end;
  logic           pass_end;
  logic           more_passes;
  logic           is_tone;
  logic [TCW-1:0] tone_top;

  // Out-of-range track selects fall back to track 0.
  assign start_trk   = (32'(bus.TRCK) >= N_TRACKS) ? 2'd0 : bus.TRCK;
  assign nxt_idx     = 6'(step_q) + 6'd1;
  assign nxt_code    = rom_note(trk_q, nxt_idx);
  assign note_end    = (note_cnt_q == NCW'(NOTE_TICKS - 1));
  assign pass_end    = (nxt_idx == 6'(TRACK_LEN)) || (nxt_code == CODE_END);
  assign more_passes = ((32'(pass_q) + 32'd1) < REPEATS);
  assign is_tone     = (note_q != 4'd0) && (note_q <= 4'd7);
  assign tone_top    = half_m1(note_q);

  // State and datapath registers.
  always_ff @(posedge CLK) begin
    if (RST) begin
      state_q    <= S_IDLE;
      trk_q      <= '0;
      step_q     <= '0;
      note_q     <= '0;
      pass_q     <= '0;
      note_cnt_q <= '0;
      tone_cnt_q <= '0;
      beep_q     <= 1'b0;
      busy_q     <= 1'b0;
      done_q     <= 1'b0;
    end else begin
      state_q    <= state_d;
      trk_q      <= trk_d;
      step_q     <= step_d;
      note_q     <= note_d;
      pass_q     <= pass_d;
      note_cnt_q <= note_cnt_d;
      tone_cnt_q <= tone_cnt_d;
      beep_q     <= beep_d;
      busy_q     <= busy_d;
      done_q     <= done_d;
    end
  end

  // Next-state and next-output logic; STOP outranks TRIG in every state.
  always_comb begin
    logic do_start;
    logic do_idle;

    state_d    = state_q;
    trk_d      = trk_q;
    step_d     = step_q;
    note_d     = note_q;
    pass_d     = pass_q;
    note_cnt_d = note_cnt_q;
    tone_cnt_d = tone_cnt_q;
    beep_d     = beep_q;
    busy_d     = busy_q;
    done_d     = 1'b0;
    do_start   = 1'b0;
    do_idle    = 1'b0;

    case (state_q)
      S_IDLE: begin
        if (bus.TRIG && !bus.STOP) do_start = 1'b1;
      end

      S_PLAY: begin
        if (bus.STOP) begin
          do_idle = 1'b1;
        end else if (bus.TRIG) begin
          do_start = 1'b1;
        end else if (note_end) begin
          // Every new step begins with a low output and a fresh tone phase.
          note_cnt_d = '0;
          tone_cnt_d = '0;
          beep_d     = 1'b0;
          if (pass_end) begin
            if (more_passes) begin
              step_d = '0;
              note_d = rom_note(trk_q, 6'd0);
              pass_d = pass_q + 4'd1;
            end else begin
              do_idle = 1'b1;
              done_d  = 1'b1;
            end
          end else begin
            step_d = SW'(nxt_idx);
            note_d = nxt_code;
          end
        end else begin
          note_cnt_d = note_cnt_q + NCW'(1);
          if (is_tone) begin
            if (tone_cnt_q == tone_top) begin
              tone_cnt_d = '0;
              beep_d     = ~beep_q;
            end else begin
              tone_cnt_d = tone_cnt_q + TCW'(1);
            end
          end else begin
            tone_cnt_d = '0;
            beep_d     = 1'b0;
          end
        end
      end

      default: do_idle = 1'b1;
    endcase

    if (do_start) begin
      state_d    = S_PLAY;
      trk_d      = start_trk;
      step_d     = '0;
      note_d     = rom_note(start_trk, 6'd0);
      pass_d     = '0;
      note_cnt_d = '0;
      tone_cnt_d = '0;
      beep_d     = 1'b0;
      busy_d     = 1'b1;
    end

    if (do_idle) begin
      state_d    = S_IDLE;
      step_d     = '0;
      note_d     = '0;
      pass_d     = '0;
      note_cnt_d = '0;
      tone_cnt_d = '0;
      beep_d     = 1'b0;
      busy_d     = 1'b0;
    end
  end

  assign bus.BEEP = beep_q;
  assign bus.BUSY = busy_q;
  assign bus.DONE = done_q;
  assign bus.STEP = step_q;
  assign bus.NOTE = note_q;

endmodule
